oam_dma_ctrl: RTL and testbench

//  Sprite-DMA engine on the CPU bus, between cpu_top and mem. Snoops CPU writes.
//  A write of page P to DMA_REG halts the CPU via rdy_out, then copies bytes
//  {P,8'h00}..{P,8'hFF} to OAM_DATA as read/write pairs, then releases the CPU.

---
 rtl/oam_dma_ctrl_pkg.sv | 15 +
 rtl/oam_dma_ctrl.sv | 114 +++++++++++
 tb/tb_oam_dma_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/oam_dma_ctrl_pkg.sv
// Shared types and default addresses for the sprite-DMA engine.
package oam_dma_ctrl_pkg;

    typedef enum logic [2:0] {
        DmaIdle,
        DmaHalt,
        DmaAlign,
        DmaRead,
        DmaWrite
    } dma_state_t;

    localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

endpackage

// File: rtl/oam_dma_ctrl.sv
// Sprite-DMA engine: halts the CPU on a DMA_REG write and copies one page
// to OAM_DATA as alternating read/write bus cycles.
module oam_dma_ctrl
    import oam_dma_ctrl_pkg::*;
#(
    parameter int unsigned              ADDR_WIDTH = 16,
    parameter int unsigned              DATA_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0]    DMA_REG    = ADDR_WIDTH'(DMA_REG_ADDR),
    parameter logic [ADDR_WIDTH-1:0]    OAM_DATA   = ADDR_WIDTH'(OAM_DATA_ADDR),
    parameter int unsigned              XFER_LEN   = 256
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_dout,
    input  logic                  cpu_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [ADDR_WIDTH-1:0] dma_addr,
    output logic [DATA_WIDTH-1:0] dma_dout,
    output logic                  dma_we,
    output logic                  bus_own,
    output logic                  rdy_out,
    output logic                  busy
);

    localparam int unsigned      IDX_W    = $clog2(XFER_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(XFER_LEN - 1);

    dma_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0] page_q, page_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  odd_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= DmaIdle;
            page_q  <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            odd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            odd_q   <= ~odd_q;
        end
    end

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        data_d  = data_q;
        case (state_q)
            DmaIdle: begin
                if (cpu_we && (cpu_addr == DMA_REG)) begin
                    page_d  = cpu_dout;
                    idx_d   = '0;
                    state_d = DmaHalt;
                end
            end
            // An extra cycle keeps the read/write pairs on a fixed cycle parity.
            DmaHalt:  state_d = odd_q ? DmaAlign : DmaRead;
            DmaAlign: state_d = DmaRead;
            DmaRead: begin
                data_d  = mem_rdata;
                state_d = DmaWrite;
            end
            DmaWrite: begin
                if (idx_q == IDX_LAST) begin
                    state_d = DmaIdle;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = DmaRead;
                end
            end
            default: state_d = DmaIdle;
        endcase
    end

    // Outputs decode only registered state, so async reset clears them at once.
    always_comb begin
        rdy_out  = 1'b1;
        busy     = 1'b0;
        bus_own  = 1'b0;
        dma_addr = '0;
        dma_dout = '0;
        dma_we   = 1'b0;
        case (state_q)
            DmaHalt, DmaAlign: begin
                rdy_out = 1'b0;
                busy    = 1'b1;
            end
            DmaRead: begin
                rdy_out  = 1'b0;
                busy     = 1'b1;
                bus_own  = 1'b1;
                dma_addr = ADDR_WIDTH'({page_q, idx_q});
            end
            DmaWrite: begin
                rdy_out  = 1'b0;
                busy     = 1'b1;
                bus_own  = 1'b1;
                dma_addr = OAM_DATA;
                dma_dout = data_q;
                dma_we   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl with a byte-array memory model.
module tb_oam_dma_ctrl;

    localparam logic [15:0] OAM  = 16'h2004;
    localparam logic [15:0] DREG = 16'h4014;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_dout = '0;
    logic        cpu_we = 1'b0;
    logic [7:0]  mem_rdata;
    logic [15:0] dma_addr;
    logic [7:0]  dma_dout;
    logic        dma_we, bus_own, rdy_out, busy;

    logic [7:0]  mem [0:65535];
    assign mem_rdata = mem[dma_addr];

    int          n_checks = 0;
    int          n_fail = 0;
    int unsigned cyc;
    logic [7:0]  wq[$];
    logic [15:0] wa[$];
    logic [15:0] rq[$];

    oam_dma_ctrl dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cpu_addr (cpu_addr),
        .cpu_dout (cpu_dout),
        .cpu_we   (cpu_we),
        .mem_rdata(mem_rdata),
        .dma_addr (dma_addr),
        .dma_dout (dma_dout),
        .dma_we   (dma_we),
        .bus_own  (bus_own),
        .rdy_out  (rdy_out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Clocks since reset; its parity is the alignment reference.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (dma_we) begin
            wq.push_back(dma_dout);
            wa.push_back(dma_addr);
        end
        if (bus_own && !dma_we) rq.push_back(dma_addr);
    end

    task automatic fill_page(input logic [7:0] p, input bit pattern);
        for (int i = 0; i < 256; i++)
            mem[{p, 8'(i)}] = pattern ? (8'(i) ^ 8'hA5) : 8'($urandom);
    endtask

    function automatic int data_errs(input logic [7:0] p, input bit pattern);
        int e = 0;
        logic [7:0] ev;
        if (wq.size() != 256 || rq.size() != 256) return 1000;
        for (int i = 0; i < 256; i++) begin
            ev = pattern ? (8'(i) ^ 8'hA5) : mem[{p, 8'(i)}];
            if (wq[i] !== ev) e++;
            if (wa[i] !== OAM) e++;
            if (rq[i] !== {p, 8'(i)}) e++;
        end
        return e;
    endfunction

    // Drives one trigger at a negedge and measures the halt window; no checks here.
    task automatic run_transfer(input logic [7:0] p, input bit inject, output int low,
                                output int halt_cyc, output int busy_bad, output bit tmo,
                                output int exp_low);
        bit injected = 1'b0;
        bit done = 1'b0;
        wq.delete(); wa.delete(); rq.delete();
        exp_low  = 513 + int'((cyc + 1) % 2);
        low      = 0;
        halt_cyc = 0;
        busy_bad = 0;
        cpu_addr = DREG;
        cpu_dout = p;
        cpu_we   = 1'b1;
        for (int k = 0; k < 700; k++) begin
            @(negedge clk);
            if (inject && dma_we && !injected) begin
                cpu_addr = DREG;
                cpu_dout = ~p;
                cpu_we   = 1'b1;
                injected = 1'b1;
            end else begin
                cpu_we = 1'b0;
            end
            if (busy !== !rdy_out) busy_bad++;
            if (rdy_out) begin
                done = 1'b1;
                break;
            end
            low++;
            if (!bus_own) halt_cyc++;
        end
        tmo = !done;
    endtask

    task automatic test_reset();
        n_checks++; if (rdy_out !== 1'b1) begin n_fail++; $display("FAIL rst_rdy: got %b expected 1", rdy_out); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
        n_checks++; if (bus_own !== 1'b0) begin n_fail++; $display("FAIL rst_own: got %b expected 0", bus_own); end
        n_checks++; if (dma_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b expected 0", dma_we); end
        n_checks++; if (dma_addr !== 16'h0) begin n_fail++; $display("FAIL rst_addr: got %h expected 0000", dma_addr); end
        n_checks++; if (dma_dout !== 8'h0) begin n_fail++; $display("FAIL rst_dout: got %h expected 00", dma_dout); end
    endtask

    task automatic test_parity(input bit want_align);
        int low, halt, bb, el, e;
        bit tmo;
        fill_page(8'h02, 1'b1);
        while ((cyc % 2) != (want_align ? 0 : 1)) @(negedge clk);
        run_transfer(8'h02, 1'b0, low, halt, bb, tmo, el);
        e = data_errs(8'h02, 1'b1);
        n_checks++; if (tmo) begin n_fail++; $display("FAIL par%0d_timeout: got 1 expected 0", want_align); end
        n_checks++; if (low !== 513 + int'(want_align)) begin n_fail++; $display("FAIL par%0d_low: got %0d expected %0d", want_align, low, 513 + int'(want_align)); end
        n_checks++; if (halt !== 1 + int'(want_align)) begin n_fail++; $display("FAIL par%0d_halt: got %0d expected %0d", want_align, halt, 1 + int'(want_align)); end
        n_checks++; if (bb !== 0) begin n_fail++; $display("FAIL par%0d_busy: got %0d bad cycles expected 0", want_align, bb); end
        n_checks++; if (e !== 0) begin n_fail++; $display("FAIL par%0d_data: got %0d errors expected 0", want_align, e); end
    endtask

    task automatic test_reset_mid();
        int low, halt, bb, el, e, k;
        bit tmo;
        logic [7:0] p;
        p = 8'($urandom);
        fill_page(p, 1'b0);
        cpu_addr = DREG; cpu_dout = p; cpu_we = 1'b1;
        @(negedge clk);
        cpu_we = 1'b0;
        for (k = 0; k < 400; k++) begin
            if (bus_own && !dma_we && dma_addr == {p, 8'h40}) break;
            @(negedge clk);
        end
        n_checks++; if (k >= 400) begin n_fail++; $display("FAIL mid_reach: got timeout expected READ of idx 40"); end
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (rdy_out !== 1'b1) begin n_fail++; $display("FAIL mid_rdy: got %b expected 1", rdy_out); end
        n_checks++; if (bus_own !== 1'b0) begin n_fail++; $display("FAIL mid_own: got %b expected 0", bus_own); end
        n_checks++; if (dma_we !== 1'b0) begin n_fail++; $display("FAIL mid_we: got %b expected 0", dma_we); end
        @(negedge clk);
        reset_n = 1'b1;
        wq.delete();
        low = 0;
        repeat (40) begin
            @(negedge clk);
            if (!rdy_out) low++;
        end
        n_checks++; if (low !== 0) begin n_fail++; $display("FAIL mid_idle_low: got %0d expected 0", low); end
        n_checks++; if (wq.size() !== 0) begin n_fail++; $display("FAIL mid_idle_wr: got %0d expected 0", wq.size()); end
        run_transfer(p, 1'b0, low, halt, bb, tmo, el);
        e = data_errs(p, 1'b0);
        n_checks++; if (tmo || low !== el || e !== 0) begin n_fail++; $display("FAIL mid_recover: got low %0d err %0d expected low %0d err 0", low, e, el); end
    endtask

    task automatic test_decoy();
        int low;
        logic [15:0] addrs [4];
        addrs[0] = 16'h4013; addrs[1] = 16'h4015; addrs[2] = 16'h4014; addrs[3] = 16'h0000;
        for (int n = 0; n < 12; n++) begin
            int s = int'($urandom_range(0, 3));
            cpu_addr = (s == 3) ? (16'($urandom) | 16'h8000) : addrs[s];
            cpu_dout = 8'($urandom);
            cpu_we   = (s != 2);
            low = 0;
            repeat (3) begin
                @(negedge clk);
                cpu_we = 1'b0;
                if (!rdy_out || busy) low++;
            end
            n_checks++; if (low !== 0) begin n_fail++; $display("FAIL decoy_%h_we%0d: got %0d halted cycles expected 0", cpu_addr, int'(s != 2), low); end
        end
    endtask

    task automatic test_back_to_back();
        int low, halt, bb, el, e;
        bit tmo;
        logic [7:0] pa, pb, pc;
        pa = 8'($urandom); pb = pa ^ 8'h5A; pc = 8'($urandom);
        fill_page(pa, 1'b0); fill_page(pb, 1'b0); fill_page(pc, 1'b0);
        run_transfer(pa, 1'b1, low, halt, bb, tmo, el);
        e = data_errs(pa, 1'b0);
        n_checks++; if (tmo || low !== el || e !== 0) begin n_fail++; $display("FAIL b2b_first: got low %0d err %0d expected low %0d err 0", low, e, el); end
        // Trigger lands in the first IDLE cycle after completion.
        run_transfer(pb, 1'b0, low, halt, bb, tmo, el);
        e = data_errs(pb, 1'b0);
        n_checks++; if (tmo || low !== el) begin n_fail++; $display("FAIL b2b_second_low: got %0d expected %0d", low, el); end
        n_checks++; if (e !== 0) begin n_fail++; $display("FAIL b2b_second_data: got %0d errors expected 0", e); end
        run_transfer(pc, 1'b1, low, halt, bb, tmo, el);
        low = 0;
        repeat (6) begin
            @(negedge clk);
            if (!rdy_out) low++;
        end
        n_checks++; if (low !== 0) begin n_fail++; $display("FAIL b2b_no_queue: got %0d halted cycles expected 0", low); end
    endtask

    task automatic test_last_page();
        int low, halt, bb, el, e;
        bit tmo;
        fill_page(8'hFF, 1'b0);
        run_transfer(8'hFF, 1'b0, low, halt, bb, tmo, el);
        e = data_errs(8'hFF, 1'b0);
        n_checks++; if (tmo || low !== el) begin n_fail++; $display("FAIL last_low: got %0d expected %0d", low, el); end
        n_checks++; if (rq.size() == 0 || rq[rq.size()-1] !== 16'hFFFF) begin n_fail++; $display("FAIL last_addr: got %0d reads expected final FFFF", rq.size()); end
        n_checks++; if (e !== 0) begin n_fail++; $display("FAIL last_data: got %0d errors expected 0", e); end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_parity(1'b0);
        test_parity(1'b1);
        test_reset_mid();
        test_decoy();
        test_back_to_back();
        test_last_page();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
